// File: rtl/cpu_io_port_pkg.sv
// Shared constants and helpers for the CPU I/O port: register offsets,
// default pin masks and the per-bit read-back selection.
package io_port_pkg;

    localparam int unsigned OFS_DDR  = 32'd0;
    localparam int unsigned OFS_DATA = 32'd1;

    localparam logic [7:0]  DEF_PULLUP_MASK  = 8'h3F;
    localparam logic [7:0]  DEF_FLOAT_MASK   = 8'hC0;
    localparam logic [19:0] DEF_DECAY_CYCLES = 20'd350000;

    // Value seen by the CPU for one bit of the DATA register.
    // Driven bits return the latch; floating bits return the decaying hold;
    // pulled-up inputs always read 1, plain inputs return the pin.
    function automatic logic port_read_bit(
        input logic ddr_b,
        input logic data_b,
        input logic float_b,
        input logic hold_b,
        input logic pullup_b,
        input logic pin_b
    );
        logic r;
        if (ddr_b) begin
            r = data_b;
        end else if (float_b) begin
            r = hold_b;
        end else begin
            r = pin_b | pullup_b;
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_io_port_if.sv
// CPU-side bus between the core and the I/O port.
interface cpu_io_port_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] AB;
    logic [7:0]        DO;
    logic              WE;
    logic              RDY;
    logic [7:0]        DI;
    logic [7:0]        CPU_DI;

    modport master (
        output AB, DO, WE, RDY, DI,
        input  CPU_DI
    );

    modport slave (
        input  AB, DO, WE, RDY, DI,
        output CPU_DI
    );
endinterface

// File: rtl/cpu_io_port_decay_bit.sv
// One floating port bit: remembers the last driven level for a limited
// number of cycles after the bit becomes an input, then decays to 0.
module io_port_decay_bit #(
    parameter int                 DECAY_W      = 20,
    parameter logic [DECAY_W-1:0] DECAY_CYCLES = DECAY_W'(20'd350000)
) (
    input  logic clk,
    input  logic reset,
    input  logic ddr_bit,
    input  logic data_bit,
    output logic hold
);

    localparam logic [DECAY_W-1:0] CNT_ONE  = DECAY_W'(1'b1);
    localparam logic [DECAY_W-1:0] CNT_ZERO = '0;

    logic [DECAY_W-1:0] cnt_d, cnt_q;
    logic               hold_d, hold_q;

    // Next-state: reload while driven, count down while floating, saturate at 0.
    always_comb begin
        cnt_d  = cnt_q;
        hold_d = hold_q;
        if (ddr_bit) begin
            hold_d = data_bit;
            cnt_d  = DECAY_CYCLES;
        end else if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (cnt_q == CNT_ONE) begin
            cnt_d  = CNT_ZERO;
            hold_d = 1'b0;
        end else begin
            cnt_d  = cnt_q;
            hold_d = hold_q;
        end
    end

    // Counter and hold flops, cleared by reset even mid-decay.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= CNT_ZERO;
            hold_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    assign hold = hold_q;

endmodule

// File: rtl/cpu_io_port.sv
// On-chip CPU I/O port: DDR at BASE, DATA at BASE+1, registered read mux
// toward the core and registered pin drive with pull-ups and floating bits.
module cpu_io_port
    import io_port_pkg::*;
#(
    parameter int                 WIDTH        = 8,
    parameter int                 ADDR_W       = 16,
    parameter logic [ADDR_W-1:0]  BASE         = '0,
    parameter logic [WIDTH-1:0]   PULLUP_MASK  = WIDTH'(DEF_PULLUP_MASK),
    parameter logic [WIDTH-1:0]   FLOAT_MASK   = WIDTH'(DEF_FLOAT_MASK),
    parameter int                 DECAY_W      = 20,
    parameter logic [DECAY_W-1:0] DECAY_CYCLES = DECAY_W'(DEF_DECAY_CYCLES)
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_io_port_if.slave          bus,
    input  logic [WIDTH-1:0]      PI,
    output logic [WIDTH-1:0]      PO,
    output logic [WIDTH-1:0]      PD
);

    // Both addresses wrap modulo 2^ADDR_W, so BASE = all-ones puts DATA at 0.
    localparam logic [ADDR_W-1:0] DDR_ADDR  = BASE + ADDR_W'(OFS_DDR);
    localparam logic [ADDR_W-1:0] DATA_ADDR = BASE + ADDR_W'(OFS_DATA);

    logic             hit_ddr_s, hit_data_s;
    logic [WIDTH-1:0] ddr_d, ddr_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic [WIDTH-1:0] po_d, po_q;
    logic [WIDTH-1:0] pd_d, pd_q;
    logic [7:0]       cpu_di_d, cpu_di_q;
    logic [WIDTH-1:0] hold_s;
    logic [WIDTH-1:0] rd_port_s;

    assign hit_ddr_s  = (bus.AB == DDR_ADDR);
    assign hit_data_s = (bus.AB == DATA_ADDR);

    // Floating bits get a decay cell; every other bit has a constant-0 hold.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (FLOAT_MASK[i]) begin : g_float
            io_port_decay_bit #(
                .DECAY_W      (DECAY_W),
                .DECAY_CYCLES (DECAY_CYCLES)
            ) u_decay (
                .clk      (clk),
                .reset    (reset),
                .ddr_bit  (ddr_q[i]),
                .data_bit (data_q[i]),
                .hold     (hold_s[i])
            );
        end else begin : g_fixed
            assign hold_s[i] = 1'b0;
        end
    end

    // Per-bit DATA read-back value.
    always_comb begin
        rd_port_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rd_port_s[i] = port_read_bit(ddr_q[i], data_q[i], FLOAT_MASK[i],
                                         hold_s[i], PULLUP_MASK[i], PI[i]);
        end
    end

    // Register writes, read mux and pin drive next-state.
    always_comb begin
        ddr_d    = ddr_q;
        data_d   = data_q;
        cpu_di_d = cpu_di_q;
        if (bus.RDY && bus.WE) begin
            if (hit_ddr_s) begin
                ddr_d = bus.DO[WIDTH-1:0];
            end else if (hit_data_s) begin
                data_d = bus.DO[WIDTH-1:0];
            end else begin
                ddr_d  = ddr_q;
                data_d = data_q;
            end
        end else if (bus.RDY) begin
            case ({hit_ddr_s, hit_data_s})
                2'b10:   cpu_di_d = 8'(ddr_q);
                2'b01:   cpu_di_d = 8'(rd_port_s);
                default: cpu_di_d = bus.DI;
            endcase
        end else begin
            cpu_di_d = cpu_di_q;
        end
        po_d = (data_q & ddr_q) | (~ddr_q & PULLUP_MASK);
        pd_d = ddr_q;
    end

    // Port state flops; pins idle at the pull-up pattern after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ddr_q    <= '0;
            data_q   <= '0;
            cpu_di_q <= 8'h00;
            po_q     <= PULLUP_MASK;
            pd_q     <= '0;
        end else begin
            ddr_q    <= ddr_d;
            data_q   <= data_d;
            cpu_di_q <= cpu_di_d;
            po_q     <= po_d;
            pd_q     <= pd_d;
        end
    end

    assign bus.CPU_DI = cpu_di_q;
    assign PO         = po_q;
    assign PD         = pd_q;

endmodule

// File: tb/tb_cpu_io_port.sv
// Bench for cpu_io_port: a fast-decay 8-bit port, a 4-bit port at 00FE and
// an 8-bit-address port whose DATA register wraps to address 0.
module tb_cpu_io_port;

    logic        clk;
    logic        reset;
    logic [15:0] ab;
    logic [7:0]  dout;
    logic        we;
    logic        rdy;
    logic [7:0]  di;
    logic [7:0]  pi;

    logic [7:0]  po8, pd8, pow, pdw;
    logic [3:0]  po4, pd4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      tag;
    } rd_t;
    rd_t sb[$];

    cpu_io_port_if #(.ADDR_W(16)) bus8 ();
    cpu_io_port_if #(.ADDR_W(16)) bus4 ();
    cpu_io_port_if #(.ADDR_W(8))  busw ();

    assign bus8.AB = ab;       assign bus4.AB = ab;       assign busw.AB = ab[7:0];
    assign bus8.DO = dout;     assign bus4.DO = dout;     assign busw.DO = dout;
    assign bus8.WE = we;       assign bus4.WE = we;       assign busw.WE = we;
    assign bus8.RDY = rdy;     assign bus4.RDY = rdy;     assign busw.RDY = rdy;
    assign bus8.DI = di;       assign bus4.DI = di;       assign busw.DI = di;

    cpu_io_port #(
        .WIDTH(8), .ADDR_W(16), .BASE(16'h0000),
        .PULLUP_MASK(8'h3F), .FLOAT_MASK(8'hC0),
        .DECAY_W(20), .DECAY_CYCLES(20'd16)
    ) dut8 (
        .clk(clk), .reset(reset), .bus(bus8), .PI(pi), .PO(po8), .PD(pd8)
    );

    cpu_io_port #(
        .WIDTH(4), .ADDR_W(16), .BASE(16'h00FE),
        .PULLUP_MASK(4'h3), .FLOAT_MASK(4'h0),
        .DECAY_W(20), .DECAY_CYCLES(20'd16)
    ) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .PI(pi[3:0]), .PO(po4), .PD(pd4)
    );

    cpu_io_port #(
        .WIDTH(8), .ADDR_W(8), .BASE(8'hFF),
        .PULLUP_MASK(8'h3F), .FLOAT_MASK(8'hC0),
        .DECAY_W(20), .DECAY_CYCLES(20'd16)
    ) dutw (
        .clk(clk), .reset(reset), .bus(busw), .PI(pi), .PO(pow), .PD(pdw)
    );

    // Free-running CPU clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bound the whole run in case something stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] cpu_di_of(input int sel);
        case (sel)
            0:       return bus8.CPU_DI;
            1:       return bus4.CPU_DI;
            default: return busw.CPU_DI;
        endcase
    endfunction

    // One clock with the given bus values; outputs are sampled 1 time unit after the edge.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d,
                             input logic w, input logic r, input logic [7:0] dbus);
        ab = a; dout = d; we = w; rdy = r; di = dbus;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        bus_cycle(a, d, 1'b1, 1'b1, di);
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus_cycle(16'h8000, 8'h00, 1'b0, 1'b0, di);
        end
    endtask

    // Read through the scoreboard: expectation queued with the stimulus,
    // compared once the registered read data is out.
    task automatic do_read(input int sel, input logic [15:0] a, input logic r,
                           input logic [7:0] dbus, input logic [7:0] exp, input string tag);
        rd_t e, got;
        e.sel = sel; e.exp = exp; e.tag = tag;
        sb.push_back(e);
        bus_cycle(a, 8'h00, 1'b0, r, dbus);
        if (sb.size() == 0) begin
            check_eq("sb_empty", 8'h00, 8'h01);
        end else begin
            got = sb.pop_front();
            check_eq(got.tag, cpu_di_of(got.sel), got.exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        ab = 16'h8000; dout = 8'h00; we = 1'b0; rdy = 1'b0; di = 8'h00; pi = 8'h00;
        reset = 1'b1;
        idle(2);
        check_eq("rst_cpu_di", bus8.CPU_DI, 8'h00);
        check_eq("rst_po", po8, 8'h3F);
        check_eq("rst_pd", pd8, 8'h00);
        reset = 1'b0;

        // Reset read-back
        pi = 8'h00;
        do_read(0, 16'h0000, 1'b1, 8'h00, 8'h00, "rd_ddr_rst");
        do_read(0, 16'h0001, 1'b1, 8'h00, 8'h3F, "rd_data_rst");

        // Pin drive with one cycle of latency
        do_write(16'h0000, 8'h2F);
        check_eq("pd_latency", pd8, 8'h00);
        do_write(16'h0001, 8'h05);
        check_eq("pd_after", pd8, 8'h2F);
        idle(1);
        check_eq("po_after", po8, 8'h15);
        pi = 8'hFF;
        do_read(0, 16'h0001, 1'b1, 8'h00, 8'h15, "rd_data_mix");

        // Decay of floating bits 7:6
        do_write(16'h0000, 8'hC0);
        do_read(0, 16'h0000, 1'b1, 8'h00, 8'hC0, "rd_ddr_b2b");
        do_write(16'h0001, 8'hC0);
        do_read(0, 16'h0001, 1'b1, 8'h00, 8'hFF, "rd_data_drv");
        do_write(16'h0000, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            do_read(0, 16'h0001, 1'b1, 8'h00, (k <= 16) ? 8'hFF : 8'h3F, $sformatf("decay_%0d", k));
        end

        // External bus reads and RDY/WE freezing
        do_read(0, 16'h1234, 1'b1, 8'hA5, 8'hA5, "rd_ext");
        do_read(0, 16'h1234, 1'b0, 8'h5A, 8'hA5, "rd_rdy0_hold");
        di = 8'h3C;
        do_write(16'h1234, 8'h77);
        check_eq("we_hold", bus8.CPU_DI, 8'hA5);
        bus_cycle(16'h0000, 8'hFF, 1'b1, 1'b0, 8'h00);
        we = 1'b0;
        do_read(0, 16'h0000, 1'b1, 8'h00, 8'h00, "wr_rdy0_ignored");

        // Reset in the middle of a decay
        do_write(16'h0000, 8'hC0);
        do_write(16'h0000, 8'h00);
        idle(10);
        do_read(0, 16'h0001, 1'b1, 8'h00, 8'hFF, "mid_decay_hold");
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_eq("mid_rst_po", po8, 8'h3F);
        check_eq("mid_rst_cpu_di", bus8.CPU_DI, 8'h00);
        do_read(0, 16'h0001, 1'b1, 8'h00, 8'h3F, "mid_rst_hold");

        // 4-bit port at 00FE
        do_reset();
        pi = 8'h00;
        do_write(16'h00FE, 8'h0F);
        do_write(16'h00FF, 8'h09);
        idle(1);
        check_eq("w4_po", {4'h0, po4}, 8'h09);
        check_eq("w4_pd", {4'h0, pd4}, 8'h0F);
        do_read(1, 16'h00FE, 1'b1, 8'h00, 8'h0F, "w4_rd_ddr");
        do_read(1, 16'h00FF, 1'b1, 8'h00, 8'h09, "w4_rd_data");

        // DATA address wrapping to 0 with BASE = all-ones
        do_reset();
        do_write(16'h00FF, 8'hFF);
        do_write(16'h0000, 8'h5A);
        idle(1);
        check_eq("wrap_po", pow, 8'h5A);
        check_eq("wrap_pd", pdw, 8'hFF);
        do_read(2, 16'h0000, 1'b1, 8'h00, 8'h5A, "wrap_rd_data");
        do_read(2, 16'h0001, 1'b1, 8'hC3, 8'hC3, "wrap_rd_ext");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
